mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Sequencer for the MEM stage of the pipelined core. It sits behind the EX/MEM pipeline register and drives a variable-latency data-memory port. While a load or store is in flight it stalls the pipeline, holding the EX/MEM register and all upstream stages. It captures load data for writeback and flags misaligned or timed-out accesses.

## Interface
- WIDTH, 32, data/address width
- TIMEOUT, 15, maximum ACCESS cycles waited for mem_ready before the access is aborted (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- MemWriteM  in  1  store request from the EX/MEM register
- MemtoRegM  in  1  load request from the EX/MEM register
- FlushM  in  1  kill the MEM-stage op; sampled only in IDLE
- ALUResultM  in  WIDTH  byte address
- WriteDataM  in  WIDTH  store data
- mem_ready  in  1  memory completes the current request
- mem_rdata  in  WIDTH  load data; valid when mem_ready=1
- err_clr  in  1  clears mem_err
- StallM  out  1  hold the EX/MEM register and upstream stages
- mem_req  out  1  request strobe to memory
- mem_we  out  1  1=write, 0=read; valid with mem_req
- mem_addr  out  WIDTH  equals ALUResultM during ACCESS
- mem_wdata  out  WIDTH  equals WriteDataM during ACCESS
- ReadDataW  out  WIDTH  registered load result
- MemDoneW  out  1  one-cycle pulse when the op retires
- mem_err  out  1  sticky error flag

## Operation
- A memory op is present when `memop = MemWriteM | MemtoRegM`. If both bits are set, the op is treated as a store.
- The FSM has three states: IDLE, ACCESS and DONE. State is registered; reset puts it in IDLE.
- IDLE transitions:
  - memop & ~FlushM & aligned → ACCESS.
  - memop & ~FlushM & misaligned (ALUResultM[1:0]≠0) → DONE. mem_err is set, no request is issued, and ReadDataW is left unchanged.
  - Otherwise the FSM stays in IDLE.
- ACCESS behaviour:
  - mem_req=1. mem_we=MemWriteM. Address and data are passed through from the held EX/MEM outputs.
  - The wait counter increments each ACCESS cycle.
  - mem_ready=1 → go to DONE. On a load, ReadDataW ← mem_rdata.
  - mem_ready=0 and counter==TIMEOUT-1 → go to DONE and set mem_err. ReadDataW ← 0 on a load; a store is simply dropped.
- DONE behaviour: MemDoneW=1, StallM=0, always returns to IDLE. The counter clears.
- `StallM = (IDLE & memop & ~FlushM) | ACCESS`.
- mem_err is set by a misaligned access or a timeout and stays set until err_clr=1. If set and clear occur in the same cycle, set wins.
- mem_req, mem_addr and mem_wdata are 0 outside ACCESS.
- The counter width is clog2(TIMEOUT+1).

## Timing
- Reset values: state=IDLE, counter=0, ReadDataW=0, mem_err=0, MemDoneW=0.
  - With memop=0 out of reset, the combinational outputs (StallM, mem_req, mem_we, mem_addr, mem_wdata) are also 0.
  - Reset asserted mid-ACCESS drops mem_req immediately (asynchronous) with no error set.
- Zero-wait memory (mem_ready=1 in the first ACCESS cycle):
  - Cycle sequence: IDLE(stall) → ACCESS → DONE.
  - StallM is high for 2 cycles.
  - MemDoneW is high in the third cycle, and the next op loads on the edge ending DONE.
- A memory with k wait cycles adds k ACCESS cycles.
- Timeout: mem_req is high for exactly TIMEOUT cycles. mem_ready arriving in the TIMEOUT-th cycle counts as success.
- DONE never re-triggers an access, even though memop is still visible that cycle. A new op is evaluated in the following IDLE.
- FlushM is ignored in ACCESS; a started access always completes or times out.
- Back-to-back ops: each costs at least 3 cycles, with no idle gap required between them.

## Test plan
- Reset then load from 0x100, mem_ready=1 in the first ACCESS cycle, mem_rdata=0xDEADBEEF.
  - StallM is high for 2 cycles, with mem_req=1 and mem_we=0 in ACCESS.
  - ReadDataW=0xDEADBEEF and MemDoneW pulses in cycle 3.
- Store of 0x12345678 to 0x40 with mem_ready delayed 3 cycles.
  - mem_req=1 and mem_we=1 for 4 cycles, with addr and data held stable.
  - StallM is high for 5 cycles, and mem_err=0 afterwards.
- Load with mem_ready never asserted, TIMEOUT=15.
  - mem_req is high exactly 15 cycles.
  - mem_err=1, ReadDataW=0, MemDoneW pulses once.
  - err_clr=1 returns mem_err to 0.
- Misaligned load at 0x102: no mem_req, StallM is high 1 cycle, mem_err=1, ReadDataW is unchanged.
- Flush and back-to-back checks:
  - FlushM=1 with a store present in IDLE: no mem_req, StallM=0.
  - Back-to-back loads to 0x0 and 0x4 with zero-wait memory: two MemDoneW pulses 3 cycles apart.
- Reset asserted while in ACCESS: mem_req drops at once; after release the FSM is in IDLE with all outputs 0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer driving a variable-latency data memory port.
module mem_stage_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWriteM,
    input  logic             MemtoRegM,
    input  logic             FlushM,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             err_clr,
    output logic             StallM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] ReadDataW,
    output logic             MemDoneW,
    output logic             mem_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          memop, is_load, misaligned, start, timeout, err_set;
    assign memop      = MemWriteM | MemtoRegM;
    assign is_load    = MemtoRegM & ~MemWriteM;
    assign misaligned = |ALUResultM[1:0];
    assign start      = (state == IDLE) & memop & ~FlushM;
    assign timeout    = (state == ACCESS) & ~mem_ready & (cnt == CW'(TIMEOUT - 1));
    assign err_set    = (start & misaligned) | timeout;
    assign StallM     = start | (state == ACCESS);
    assign mem_req    = state == ACCESS;
    assign mem_we     = mem_req & MemWriteM;
    assign mem_addr   = mem_req ? ALUResultM : '0;
    assign mem_wdata  = mem_req ? WriteDataM : '0;
    // Set dominates clear so a same-cycle error is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ReadDataW <= '0;
            mem_err   <= 1'b0;
            MemDoneW  <= 1'b0;
        end else begin
            mem_err  <= err_set | (mem_err & ~err_clr);
            MemDoneW <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= misaligned ? DONE : ACCESS;
                    MemDoneW <= misaligned;
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ready | timeout) begin
                        state    <= DONE;
                        MemDoneW <= 1'b1;
                        if (is_load) ReadDataW <= mem_ready ? mem_rdata : '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench with a transaction-level model of the MEM stage.
module tb_mem_stage_ctrl;
    localparam int W = 32;
    localparam int T = 15;
    logic         clk = 0, reset = 0;
    logic         MemWriteM = 0, MemtoRegM = 0, FlushM = 0, err_clr = 0, mem_ready = 0;
    logic [W-1:0] ALUResultM = 0, WriteDataM = 0, mem_rdata = 0;
    logic         StallM, mem_req, mem_we, MemDoneW, mem_err;
    logic [W-1:0] mem_addr, mem_wdata, ReadDataW;

    mem_stage_ctrl #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .FlushM(FlushM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err_clr(err_clr),
        .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .ReadDataW(ReadDataW), .MemDoneW(MemDoneW), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] addr, wdata, rd;
        logic         we, err;
        int           nreq, stall;
    } exp_t;
    exp_t         sb[$];
    int           ntot = 0, npass = 0;
    logic [W-1:0] rd_exp = 0;
    logic         err_exp = 0;
    int           wait_k = 0;
    logic [W-1:0] rdata_v = 0;
    int           acc_cnt = 0, nreq = 0, nstall = 0;

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    // Memory model: answers after wait_k wait cycles with rdata_v, garbage otherwise.
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ready = (acc_cnt == wait_k);
            acc_cnt++;
        end else begin
            mem_ready = 0;
            acc_cnt = 0;
        end
        mem_rdata = mem_ready ? rdata_v : W'($urandom);
    end

    // Monitor: checks every request cycle and retires one expectation per MemDoneW.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            nreq = 0;
            nstall = 0;
        end else begin
            if (StallM) nstall++;
            if (mem_req) begin
                nreq++;
                if (sb.size() == 0) chk("spurious_req", W'(mem_req), 0);
                else begin
                    chk("mem_addr", mem_addr, sb[0].addr);
                    chk("mem_we", W'(mem_we), W'(sb[0].we));
                    chk("mem_wdata", mem_wdata, sb[0].wdata);
                end
            end
            if (MemDoneW) begin
                if (sb.size() == 0) chk("spurious_done", W'(MemDoneW), 0);
                else begin
                    e = sb.pop_front();
                    chk("ReadDataW", ReadDataW, e.rd);
                    chk("mem_err", W'(mem_err), W'(e.err));
                    chk("req_cycles", nreq, e.nreq);
                    chk("stall_cycles", nstall, e.stall);
                end
                nreq = 0;
                nstall = 0;
            end
        end
    end

    task automatic start_op(input logic we, ld, fl, clr, input logic [W-1:0] a, wd,
                            input int k, input logic [W-1:0] rdv);
        exp_t e;
        wait_k = k; rdata_v = rdv;
        MemWriteM = we; MemtoRegM = ld; FlushM = fl; err_clr = clr;
        ALUResultM = a; WriteDataM = wd;
        if ((we | ld) && !fl) begin
            e.addr = a; e.wdata = wd; e.we = we; e.rd = rd_exp;
            if (a[1:0] != 0) begin
                e.nreq = 0; e.stall = 1; e.err = 1;
            end else if (k < T) begin
                e.nreq = k + 1; e.stall = k + 2; e.err = err_exp & ~clr;
                if (ld && !we) e.rd = rdv;
            end else begin
                e.nreq = T; e.stall = T + 1; e.err = 1;
                if (ld && !we) e.rd = 0;
            end
            rd_exp = e.rd; err_exp = e.err;
            sb.push_back(e);
        end
    endtask

    task automatic run_op(input logic we, ld, fl, clr, input logic [W-1:0] a, wd,
                          input int k, input logic [W-1:0] rdv, output int n);
        logic done;
        start_op(we, ld, fl, clr, a, wd, k, rdv);
        n = 0;
        if ((we | ld) && !fl) begin
            done = 0;
            while (!done && n < T + 6) begin
                @(posedge clk); #1;
                n++;
                err_clr = 0;
                FlushM = 1'($urandom);
                done = MemDoneW;
            end
            if (!done) chk("done_seen", W'(MemDoneW), 1);
            @(posedge clk); #1;
        end else begin
            #1;
            chk("idle_stall", W'(StallM), 0);
            chk("idle_req", W'(mem_req), 0);
            @(posedge clk); #1;
            err_exp &= ~clr;
            chk("idle_err", W'(mem_err), W'(err_exp));
            chk("idle_done", W'(MemDoneW), 0);
        end
    endtask

    task automatic idle(input logic clr);
        int n;
        run_op(0, 0, 0, clr, 0, 0, 0, 0, n);
    endtask

    initial begin
        int n, pick, k;
        logic [W-1:0] a;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        #1;
        chk("rst_rd", ReadDataW, 0);
        chk("rst_err", W'(mem_err), 0);
        chk("rst_done", W'(MemDoneW), 0);
        chk("rst_stall", W'(StallM), 0);
        chk("rst_req", W'(mem_req), 0);
        chk("rst_we", W'(mem_we), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        @(posedge clk); #1;

        run_op(0, 1, 0, 0, 32'h100, 0, 0, 32'hDEADBEEF, n);
        chk("zero_wait_lat", n, 2);
        chk("load_data", ReadDataW, 32'hDEADBEEF);
        run_op(1, 0, 0, 0, 32'h40, 32'h12345678, 3, 32'h0BADF00D, n);
        chk("store_lat", n, 5);
        chk("store_noerr", W'(mem_err), 0);
        run_op(0, 1, 0, 0, 32'h200, 0, 99, 32'h11111111, n);
        chk("timeout_lat", n, T + 1);
        idle(1);
        run_op(0, 1, 0, 0, 32'h104, 0, T - 1, 32'hCAFEF00D, n);
        chk("late_ready_lat", n, T + 1);
        run_op(1, 0, 0, 0, 32'h108, 32'h55AA55AA, T, 0, n);
        run_op(0, 1, 0, 1, 32'h102, 0, 0, 32'h22222222, n);
        chk("misaligned_lat", n, 1);
        idle(0);
        idle(1);
        run_op(1, 0, 1, 0, 32'h80, 32'hFFFF0000, 0, 0, n);
        run_op(0, 1, 0, 0, 32'h0, 0, 0, 32'hA5A5A5A5, n);
        run_op(0, 1, 0, 0, 32'h4, 0, 0, 32'h5A5A5A5A, n);
        chk("b2b_lat", n, 2);
        run_op(1, 1, 0, 0, 32'h10, 32'h77777777, 1, 32'h33333333, n);

        for (int i = 0; i < 200; i++) begin
            pick = $urandom_range(0, 9);
            k = pick < 6 ? $urandom_range(0, 3) : pick == 6 ? T - 1 : pick == 7 ? T : pick == 8 ? 99 : 0;
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            run_op(1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                   a, $urandom, k, $urandom, n);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3) == 0);
        end

        start_op(0, 1, 0, 0, 32'h300, 0, 99, 0);
        repeat (3) @(posedge clk);
        #1 chk("req_before_rst", W'(mem_req), 1);
        #2 reset = 0;
        #1;
        chk("rst_req_drop", W'(mem_req), 0);
        chk("rst_err_clear", W'(mem_err), 0);
        MemWriteM = 0; MemtoRegM = 0; FlushM = 0; ALUResultM = 0; WriteDataM = 0;
        sb.delete();
        rd_exp = 0; err_exp = 0;
        @(posedge clk); #1 reset = 1;
        #1;
        chk("post_rst_stall", W'(StallM), 0);
        chk("post_rst_req", W'(mem_req), 0);
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_rd", ReadDataW, 0);
        chk("post_rst_done", W'(MemDoneW), 0);
        @(posedge clk); #1;
        run_op(0, 1, 0, 0, 32'h8, 0, 2, 32'h44444444, n);
        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
